// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton conditioner.
package btn_pkg;

    // Debounce FSM: two stable levels, each with a candidate state for the other level.
    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } btn_state_t;

    // 10 ms at 100 MHz.
    localparam int BTN_DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with synchronous active-high reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: synchronize, debounce, and emit press/release strobes
// plus a press-toggled LED level. All outputs are registered.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk100mhz,
    input  logic rst,
    input  logic btn,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic led_toggle
);

    // Last counter value in a candidate state; one more matching sample accepts.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    (* mark_debug = "true" *) logic       w_s;
    (* mark_debug = "true" *) btn_state_t r_state;

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_toggle;

    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_toggle_nxt;

    sync_2ff u_sync (
        .i_clk (clk100mhz),
        .i_rst (rst),
        .i_d   (btn),
        .o_q   (w_s)
    );

    // State, counter and output registers; reset wins over any transition.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            r_state   <= ST_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_toggle  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_toggle  <= w_toggle_nxt;
        end
    end

    // Next-state logic: any sample back at the stable level drops the candidate.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_toggle_nxt  = r_toggle;
        case (r_state)
            ST_LOW: begin
                w_cnt_nxt = '0;
                if (w_s) w_state_nxt = ST_WAIT_HIGH;
            end
            ST_WAIT_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt  = ST_HIGH;
                    w_cnt_nxt    = '0;
                    w_level_nxt  = 1'b1;
                    w_press_nxt  = 1'b1;
                    w_toggle_nxt = ~r_toggle;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                w_cnt_nxt = '0;
                if (!w_s) w_state_nxt = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (w_s) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_LOW;
                    w_cnt_nxt     = '0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign led_toggle  = r_toggle;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with an 8-cycle debounce window.
module tb_btn_debounce;

    localparam int DC = 8;

    logic clk100mhz = 1'b0;
    logic rst       = 1'b1;
    logic btn       = 1'b0;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic led_toggle;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_press   = 0;
    int n_release = 0;
    int n_both    = 0;
    int p0;
    int r0;

    btn_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk100mhz   (clk100mhz),
        .rst         (rst),
        .btn         (btn),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .led_toggle  (led_toggle)
    );

    always #5 clk100mhz = ~clk100mhz;

    // Strobe counters, sampled just after each active edge.
    always @(posedge clk100mhz) begin
        #1;
        if (btn_press)               n_press++;
        if (btn_release)             n_release++;
        if (btn_press && btn_release) n_both++;
    end

    // Advance n active edges; returns at a falling edge so outputs are settled.
    task automatic tick(input int n);
        repeat (n) @(negedge clk100mhz);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_level",   btn_level,   1'b0);
        chk("rst_press",   btn_press,   1'b0);
        chk("rst_release", btn_release, 1'b0);
        chk("rst_toggle",  led_toggle,  1'b0);
        rst = 1'b0;

        // Clean press: output appears on the 11th edge after the pin change
        tick(20);
        p0 = n_press;
        btn = 1'b1;
        tick(DC + 2);
        chk("press_early_level", btn_level, 1'b0);
        chk("press_early_strb",  btn_press, 1'b0);
        tick(1);
        chk("press_level",  btn_level,  1'b1);
        chk("press_strb",   btn_press,  1'b1);
        chk("press_toggle", led_toggle, 1'b1);
        tick(1);
        chk("press_strb_off", btn_press, 1'b0);
        chk("press_lvl_hold", btn_level, 1'b1);
        chk_n("press_count", n_press - p0, 1);

        // Release after a long hold: toggle unchanged
        tick(28);
        r0 = n_release;
        btn = 1'b0;
        tick(DC + 2);
        chk("rel_early_level", btn_level,   1'b1);
        chk("rel_early_strb",  btn_release, 1'b0);
        tick(1);
        chk("rel_level",  btn_level,   1'b0);
        chk("rel_strb",   btn_release, 1'b1);
        chk("rel_toggle", led_toggle,  1'b1);
        tick(1);
        chk("rel_strb_off", btn_release, 1'b0);
        chk_n("rel_count", n_release - r0, 1);

        // Bounce: 5 high, 2 low, then held; window restarts on the final rise
        tick(10);
        p0 = n_press;
        btn = 1'b1;
        tick(5);
        btn = 1'b0;
        tick(2);
        btn = 1'b1;
        tick(DC + 2);
        chk("bounce_early_level", btn_level, 1'b0);
        chk_n("bounce_no_strb", n_press - p0, 0);
        tick(1);
        chk("bounce_level",  btn_level,  1'b1);
        chk("bounce_strb",   btn_press,  1'b1);
        chk("bounce_toggle", led_toggle, 1'b0);
        tick(1);
        chk_n("bounce_count", n_press - p0, 1);

        // Release, then a 7-cycle glitch that must be rejected
        btn = 1'b0;
        tick(20);
        chk("rel2_level", btn_level, 1'b0);
        p0 = n_press;
        r0 = n_release;
        btn = 1'b1;
        tick(7);
        btn = 1'b0;
        tick(20);
        chk("glitch_level", btn_level, 1'b0);
        chk_n("glitch_press", n_press - p0, 0);
        chk_n("glitch_rel",   n_release - r0, 0);

        // Reset mid-window at cnt=5, button still held afterwards
        p0 = n_press;
        btn = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rstw_level",  btn_level,  1'b0);
        chk("rstw_toggle", led_toggle, 1'b0);
        tick(DC + 2);
        chk("rstw_early_level", btn_level, 1'b0);
        chk_n("rstw_no_strb", n_press - p0, 0);
        tick(1);
        chk("rstw_level_acc", btn_level,  1'b1);
        chk("rstw_strb",      btn_press,  1'b1);
        chk("rstw_toggle1",   led_toggle, 1'b1);

        // Reset while stable high: no release strobe
        tick(5);
        r0 = n_release;
        rst = 1'b1;
        btn = 1'b0;
        tick(1);
        rst = 1'b0;
        chk("rsth_level",   btn_level,   1'b0);
        chk("rsth_toggle",  led_toggle,  1'b0);
        chk("rsth_release", btn_release, 1'b0);
        tick(15);
        chk_n("rsth_no_rel", n_release - r0, 0);
        chk("rsth_level2", btn_level, 1'b0);

        chk_n("no_overlap", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
